// File: rtl/rgb_to_raw.sv
// RGB to Bayer RAW (GRBG) converter: frame-sequenced FSM feeding a 2-stage output pipeline.
// Define RGB_TO_RAW_FRAME_CNT_EN to add the oFrameCount output.
module rgb_to_raw #(
   parameter int LINE_WIDTH   = 640,
   parameter int FRAME_HEIGHT = 480
) (
   input  logic        iCLK,
   input  logic        iRST_n,
   input  logic        iStart,
   input  logic [11:0] iRed,
   input  logic [11:0] iGreen,
   input  logic [11:0] iBlue,
   input  logic        iDataValid,
   output logic [11:0] oData,
   output logic        oDataValid,
   output logic [15:0] oX_Counter,
   output logic [15:0] oY_Counter,
   output logic        oFrameDone,
   output logic        oOverrun
`ifdef RGB_TO_RAW_FRAME_CNT_EN
   ,output logic [15:0] oFrameCount
`endif
);

   localparam logic [15:0] X_LAST = 16'(LINE_WIDTH - 1);
   localparam logic [15:0] Y_LAST = 16'(FRAME_HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t      r_state;
   logic [15:0] r_x, r_y;
   logic        r_s1_vld, r_s1_last;
   logic [11:0] r_s1_data;
   logic [15:0] r_s1_x, r_s1_y;

   logic        w_restart, w_take, w_eol, w_last;
   logic [15:0] w_cx, w_cy;
   logic [11:0] w_pix;

   // A restart in ACTIVE makes the same-cycle pixel the origin of the new frame.
   assign w_restart = iStart && (r_state == ACTIVE);
   assign w_cx      = w_restart ? 16'd0 : r_x;
   assign w_cy      = w_restart ? 16'd0 : r_y;
   assign w_take    = (r_state == ACTIVE) && iDataValid;
   assign w_eol     = (w_cx == X_LAST);
   assign w_last    = w_eol && (w_cy == Y_LAST);

   always_comb begin
      w_pix = iGreen;
      case ({w_cy[0], w_cx[0]})
         2'b01:   w_pix = iRed;
         2'b10:   w_pix = iBlue;
         default: w_pix = iGreen;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_state  <= IDLE;
         r_x      <= '0;
         r_y      <= '0;
         oOverrun <= 1'b0;
      end else begin
         oOverrun <= 1'b0;
         case (r_state)
            IDLE: begin
               if (iStart) begin
                  r_state <= ACTIVE;
                  r_x     <= '0;
                  r_y     <= '0;
               end
            end
            ACTIVE: begin
               oOverrun <= iStart && ((r_x != 16'd0) || (r_y != 16'd0));
               if (w_take) begin
                  if (w_last) r_state <= DONE;
                  if (w_eol) begin
                     r_x <= '0;
                     r_y <= w_cy + 16'd1;
                  end else begin
                     r_x <= w_cx + 16'd1;
                     r_y <= w_cy;
                  end
               end else if (iStart) begin
                  r_x <= '0;
                  r_y <= '0;
               end
            end
            DONE: begin
               r_state <= iStart ? ACTIVE : IDLE;
               r_x     <= '0;
               r_y     <= '0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_s1_vld   <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_data  <= '0;
         r_s1_x     <= '0;
         r_s1_y     <= '0;
         oDataValid <= 1'b0;
         oFrameDone <= 1'b0;
         oData      <= '0;
         oX_Counter <= '0;
         oY_Counter <= '0;
      end else begin
         r_s1_vld <= w_take;
         if (w_take) begin
            r_s1_last <= w_last;
            r_s1_data <= w_pix;
            r_s1_x    <= w_cx;
            r_s1_y    <= w_cy;
         end
         oDataValid <= r_s1_vld;
         oFrameDone <= r_s1_vld && r_s1_last;
         if (r_s1_vld) begin
            oData      <= r_s1_data;
            oX_Counter <= r_s1_x;
            oY_Counter <= r_s1_y;
         end
      end
   end

`ifdef RGB_TO_RAW_FRAME_CNT_EN
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n)                      oFrameCount <= '0;
      else if (r_s1_vld && r_s1_last)   oFrameCount <= oFrameCount + 16'd1;
   end
`endif

endmodule

// File: tb/tb_rgb_to_raw.sv
// Directed bench for rgb_to_raw on a 4x2 frame: vector table plus reset corner case.
module tb_rgb_to_raw;

   logic        iCLK = 1'b0;
   logic        iRST_n = 1'b0;
   logic        iStart = 1'b0;
   logic [11:0] iRed = '0, iGreen = '0, iBlue = '0;
   logic        iDataValid = 1'b0;
   logic [11:0] oData;
   logic        oDataValid;
   logic [15:0] oX_Counter, oY_Counter;
   logic        oFrameDone, oOverrun;
`ifdef RGB_TO_RAW_FRAME_CNT_EN
   logic [15:0] oFrameCount;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   rgb_to_raw #(.LINE_WIDTH(4), .FRAME_HEIGHT(2)) dut (
      .iCLK(iCLK), .iRST_n(iRST_n), .iStart(iStart),
      .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iDataValid(iDataValid),
      .oData(oData), .oDataValid(oDataValid),
      .oX_Counter(oX_Counter), .oY_Counter(oY_Counter),
      .oFrameDone(oFrameDone), .oOverrun(oOverrun)
`ifdef RGB_TO_RAW_FRAME_CNT_EN
      , .oFrameCount(oFrameCount)
`endif
   );

   always #5 iCLK = ~iCLK;

   // Each row: inputs applied this cycle; expected outputs as observed before this cycle's edge.
   typedef struct {
      logic        st, dv;
      logic [11:0] r, g, b;
      logic        ev;
      logic [11:0] ed;
      logic [15:0] ex, ey;
      logic        edn, eov;
   } vec_t;

   localparam int NV = 29;
   vec_t tv [NV];

   function automatic vec_t mk(logic st, logic dv, logic [11:0] r, logic [11:0] g, logic [11:0] b,
                               logic ev, logic [11:0] ed, logic [15:0] ex, logic [15:0] ey,
                               logic edn, logic eov);
      vec_t v;
      v.st = st; v.dv = dv; v.r = r; v.g = g; v.b = b;
      v.ev = ev; v.ed = ed; v.ex = ex; v.ey = ey; v.edn = edn; v.eov = eov;
      return v;
   endfunction

   task automatic check_out(string name, logic ev, logic [11:0] ed, logic [15:0] ex,
                            logic [15:0] ey, logic edn, logic eov);
      n_cmp++;
      if (oDataValid !== ev || oData !== ed || oX_Counter !== ex || oY_Counter !== ey ||
          oFrameDone !== edn || oOverrun !== eov) begin
         n_bad++;
         $display("FAIL %s: got vld=%0b data=%h x=%0d y=%0d done=%0b ovr=%0b, want vld=%0b data=%h x=%0d y=%0d done=%0b ovr=%0b",
                  name, oDataValid, oData, oX_Counter, oY_Counter, oFrameDone, oOverrun,
                  ev, ed, ex, ey, edn, eov);
      end
   endtask

   initial begin
      // pre-start junk, full frame, interleaved valids, mid-frame restart
      tv[0]  = mk(0,1,12'hFFF,12'hEEE,12'hDDD, 0,12'h000,0,0,0,0);
      tv[1]  = mk(1,1,12'hFFF,12'hEEE,12'hDDD, 0,12'h000,0,0,0,0);
      tv[2]  = mk(0,1,12'h100,12'h200,12'h300, 0,12'h000,0,0,0,0);
      tv[3]  = mk(0,1,12'h101,12'h201,12'h301, 0,12'h000,0,0,0,0);
      tv[4]  = mk(0,1,12'h102,12'h202,12'h302, 1,12'h200,0,0,0,0);
      tv[5]  = mk(0,1,12'h103,12'h203,12'h303, 1,12'h101,1,0,0,0);
      tv[6]  = mk(0,1,12'h104,12'h204,12'h304, 1,12'h202,2,0,0,0);
      tv[7]  = mk(0,1,12'h105,12'h205,12'h305, 1,12'h103,3,0,0,0);
      tv[8]  = mk(0,1,12'h106,12'h206,12'h306, 1,12'h304,0,1,0,0);
      tv[9]  = mk(0,1,12'h107,12'h207,12'h307, 1,12'h205,1,1,0,0);
      tv[10] = mk(0,0,12'h000,12'h000,12'h000, 1,12'h306,2,1,0,0);
      tv[11] = mk(0,0,12'h000,12'h000,12'h000, 1,12'h207,3,1,1,0);
      tv[12] = mk(0,0,12'h000,12'h000,12'h000, 0,12'h207,3,1,0,0);
      tv[13] = mk(1,0,12'h000,12'h000,12'h000, 0,12'h207,3,1,0,0);
      tv[14] = mk(0,1,12'hA01,12'hA02,12'hA03, 0,12'h207,3,1,0,0);
      tv[15] = mk(0,0,12'h000,12'h000,12'h000, 0,12'h207,3,1,0,0);
      tv[16] = mk(0,0,12'h000,12'h000,12'h000, 1,12'hA02,0,0,0,0);
      tv[17] = mk(0,1,12'hB01,12'hB02,12'hB03, 0,12'hA02,0,0,0,0);
      tv[18] = mk(0,0,12'h000,12'h000,12'h000, 0,12'hA02,0,0,0,0);
      tv[19] = mk(0,0,12'h000,12'h000,12'h000, 1,12'hB01,1,0,0,0);
      tv[20] = mk(0,1,12'hC01,12'hC02,12'hC03, 0,12'hB01,1,0,0,0);
      tv[21] = mk(0,1,12'hD01,12'hD02,12'hD03, 0,12'hB01,1,0,0,0);
      tv[22] = mk(0,1,12'hE01,12'hE02,12'hE03, 1,12'hC02,2,0,0,0);
      tv[23] = mk(0,1,12'hF01,12'hF02,12'hF03, 1,12'hD01,3,0,0,0);
      tv[24] = mk(1,1,12'h111,12'h112,12'h113, 1,12'hE03,0,1,0,0);
      tv[25] = mk(0,0,12'h000,12'h000,12'h000, 1,12'hF02,1,1,0,1);
      tv[26] = mk(0,0,12'h000,12'h000,12'h000, 1,12'h112,0,0,0,0);
      tv[27] = mk(0,1,12'h121,12'h122,12'h123, 0,12'h112,0,0,0,0);
      tv[28] = mk(0,1,12'h131,12'h132,12'h133, 0,12'h112,0,0,0,0);

      repeat (2) @(posedge iCLK);
      @(negedge iCLK);
      iRST_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge iCLK);
         check_out($sformatf("row%0d", i), tv[i].ev, tv[i].ed, tv[i].ex, tv[i].ey, tv[i].edn, tv[i].eov);
`ifdef RGB_TO_RAW_FRAME_CNT_EN
         if (i == 12) begin
            n_cmp++;
            if (oFrameCount !== 16'd1) begin
               n_bad++;
               $display("FAIL frame_count: got %0d want 1", oFrameCount);
            end
         end
`endif
         iStart = tv[i].st; iDataValid = tv[i].dv;
         iRed = tv[i].r; iGreen = tv[i].g; iBlue = tv[i].b;
      end

      // X=3,Y=0 in flight with pixel (X=1) showing at the output: async reset clears at once
      @(negedge iCLK);
      check_out("pre_reset", 1'b1, 12'h121, 16'd1, 16'd0, 1'b0, 1'b0);
      iStart = 1'b0; iDataValid = 1'b1;
      iRed = 12'h141; iGreen = 12'h142; iBlue = 12'h143;
      iRST_n = 1'b0;
      #1;
      check_out("reset_immediate", 1'b0, 12'h000, 16'd0, 16'd0, 1'b0, 1'b0);
      repeat (2) @(posedge iCLK);
      @(negedge iCLK);
      iRST_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge iCLK);
         check_out($sformatf("post_reset%0d", k), 1'b0, 12'h000, 16'd0, 16'd0, 1'b0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
